// File: rtl/bpu_btb_ras_pkg.sv
// Shared types, sizing constants and counter helpers for the BTB/RAS branch predictor.
package bpu_btb_ras_pkg;

    localparam int unsigned BTB_DEPTH = 1024;
    localparam int unsigned CTR_BITS  = 2;
    localparam int unsigned RAS_DEPTH = 8;
    localparam int unsigned IDX_W     = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W     = 32 - IDX_W - 2;
    localparam int unsigned PTR_W     = $clog2(RAS_DEPTH);

    typedef enum logic [2:0] {
        BR_NONE = 3'd0,
        BR_BRA  = 3'd1,
        BR_J    = 3'd2,
        BR_CALL = 3'd3,
        BR_RET  = 3'd4
    } br_type_e;

    typedef logic [CTR_BITS-1:0] ctr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [31:0]      target;
        br_type_e         br_type;
        ctr_t             ctr;
    } btb_entry_t;

    localparam logic [0:0] ST_IDLE       = 1'b0;
    localparam logic [0:0] ST_CORRECTION = 1'b1;

    localparam ctr_t CTR_MAX     = '1;
    localparam ctr_t CTR_WEAK_T  = ctr_t'(1) << (CTR_BITS - 1);
    localparam ctr_t CTR_WEAK_NT = CTR_WEAK_T - ctr_t'(1);

    // A wrong prediction restarts at the weak state of the actual direction.
    function automatic ctr_t ctr_next(input ctr_t c, input logic taken, input logic ok);
        ctr_t r;
        if (!ok) begin
            r = taken ? CTR_WEAK_T : CTR_WEAK_NT;
        end else if (taken) begin
            r = (c == CTR_MAX) ? c : c + ctr_t'(1);
        end else begin
            r = (c == '0) ? c : c - ctr_t'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/bpu_ras.sv
// Circular return-address stack with pointer restore; a full push overwrites the oldest entry.
module bpu_ras #(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [31:0]      i_push_data,
    input  logic             i_restore,
    input  logic [PTR_W-1:0] i_restore_ptr,
    output logic [31:0]      o_top_c,
    output logic [PTR_W-1:0] o_ptr,
    output logic [PTR_W:0]   o_count
);

    logic [31:0]      r_stack [DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W:0]   r_count;
    logic [PTR_W-1:0] w_base;
    logic [PTR_W-1:0] w_ptr_next;
    logic [PTR_W:0]   w_count_next;
    logic             w_wr;

    // The op is applied on top of the restored pointer when a restore is requested.
    always_comb begin
        w_base       = i_restore ? i_restore_ptr : r_ptr;
        w_ptr_next   = w_base;
        w_count_next = r_count;
        w_wr         = 1'b0;
        if (i_push) begin
            w_wr       = 1'b1;
            w_ptr_next = w_base + PTR_W'(1);
            if (r_count != (PTR_W+1)'(DEPTH)) begin
                w_count_next = r_count + (PTR_W+1)'(1);
            end
        end else if (i_pop && (r_count != '0)) begin
            w_ptr_next   = w_base - PTR_W'(1);
            w_count_next = r_count - (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_stack[i] <= '0;
            end
        end else begin
            r_ptr   <= w_ptr_next;
            r_count <= w_count_next;
            if (w_wr) begin
                r_stack[w_base] <= i_push_data;
            end
        end
    end

    assign o_top_c = r_stack[r_ptr - PTR_W'(1)];
    assign o_ptr   = r_ptr;
    assign o_count = r_count;

endmodule

// File: rtl/bpu_btb_ras.sv
// Fetch-stage branch predictor: direct-mapped BTB with saturating counters, a return-address
// stack with checkpoint recovery, and the IDLE/CORRECTION redirect FSM.
module bpu_btb_ras
    import bpu_btb_ras_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_fetch_valid,
    input  logic [31:0]         i_fetch_pc,
    input  logic                i_pipeline_flush,
    output logic                o_pred_valid,
    output logic                o_pred_br_op,
    output logic                o_pred_taken,
    output logic [31:0]         o_pred_target,
    output logic [PTR_W-1:0]    o_pred_ras_ptr,
    input  logic                i_verify_valid,
    input  logic [31:0]         i_verify_pc,
    input  logic [2:0]          i_verify_type,
    input  logic                i_verify_taken,
    input  logic [31:0]         i_verify_target,
    input  logic                i_verify_ok,
    input  logic [CTR_BITS-1:0] i_verify_ctr,
    input  logic [PTR_W-1:0]    i_verify_ras_ptr,
    input  logic                i_correction_finish,
    output logic                o_br_flush,
    output logic                o_is_correction,
    output logic [31:0]         o_correct_target
);

    logic [BTB_DEPTH-1:0] r_btb_valid;
    btb_entry_t           r_btb_mem [BTB_DEPTH];

    logic [IDX_W-1:0] w_fetch_idx;
    logic [IDX_W-1:0] w_verify_idx;
    btb_entry_t       w_rd_entry;
    btb_entry_t       w_wr_entry;
    br_type_e         w_verify_type;
    logic             w_hit;
    logic             w_idle;
    logic             w_mispred;
    logic             w_recover;
    logic             w_spec_ok;
    logic [31:0]      w_fetch_seq;
    logic [31:0]      w_verify_seq;

    logic             w_pred_taken;
    logic [31:0]      w_pred_target;
    logic             r_pred_valid;
    logic             r_pred_br_op;
    logic             r_pred_taken;
    logic [31:0]      r_pred_target;
    logic [PTR_W-1:0] r_pred_ras_ptr;

    logic [0:0]       r_state;
    logic [0:0]       w_state_next;
    logic [31:0]      r_correct_target;

    logic             w_ras_push;
    logic             w_ras_pop;
    logic [31:0]      w_ras_push_data;
    logic [31:0]      w_ras_top;
    logic [PTR_W-1:0] w_ras_ptr;
    logic [PTR_W:0]   w_ras_count;

    assign w_fetch_idx   = i_fetch_pc[IDX_W+1:2];
    assign w_verify_idx  = i_verify_pc[IDX_W+1:2];
    assign w_fetch_seq   = i_fetch_pc + 32'd8;
    assign w_verify_seq  = i_verify_pc + 32'd8;
    assign w_verify_type = br_type_e'(i_verify_type);

    assign w_rd_entry = r_btb_mem[w_fetch_idx];
    assign w_hit      = r_btb_valid[w_fetch_idx] & w_rd_entry.valid
                        & (w_rd_entry.tag == i_fetch_pc[31:IDX_W+2]);

    assign w_idle    = (r_state == ST_IDLE);
    assign w_mispred = i_verify_valid & ~i_verify_ok;
    assign w_recover = w_mispred & w_idle;
    assign w_spec_ok = i_fetch_valid & w_hit & w_idle;

    assign w_wr_entry = '{
        valid:   1'b1,
        tag:     i_verify_pc[31:IDX_W+2],
        target:  i_verify_target,
        br_type: w_verify_type,
        ctr:     ctr_next(i_verify_ctr, i_verify_taken, i_verify_ok)
    };

    // Valid bits carry the reset; payload storage is RAM-like and never cleared.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_btb_valid <= '0;
        end else if (i_verify_valid) begin
            r_btb_valid[w_verify_idx] <= 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_verify_valid && !i_reset) begin
            r_btb_mem[w_verify_idx] <= w_wr_entry;
        end
    end

    always_comb begin
        w_pred_taken  = 1'b0;
        w_pred_target = w_fetch_seq;
        if (w_hit) begin
            case (w_rd_entry.br_type)
                BR_J, BR_CALL: begin
                    w_pred_taken  = 1'b1;
                    w_pred_target = w_rd_entry.target;
                end
                BR_BRA: begin
                    if (w_rd_entry.ctr[CTR_BITS-1]) begin
                        w_pred_taken  = 1'b1;
                        w_pred_target = w_rd_entry.target;
                    end
                end
                BR_RET: begin
                    if (w_ras_count != '0) begin
                        w_pred_taken  = 1'b1;
                        w_pred_target = w_ras_top;
                    end
                end
                default: ;
            endcase
        end
    end

    // Recovery replays the resolved op from the checkpoint and overrides any speculative op.
    always_comb begin
        w_ras_push      = 1'b0;
        w_ras_pop       = 1'b0;
        w_ras_push_data = w_fetch_seq;
        if (w_recover) begin
            w_ras_push      = (w_verify_type == BR_CALL);
            w_ras_pop       = (w_verify_type == BR_RET);
            w_ras_push_data = w_verify_seq;
        end else if (w_spec_ok) begin
            w_ras_push = (w_rd_entry.br_type == BR_CALL);
            w_ras_pop  = (w_rd_entry.br_type == BR_RET);
        end
    end

    bpu_ras #(
        .DEPTH(RAS_DEPTH)
    ) u_ras (
        .i_clk         (i_clk),
        .i_reset       (i_reset),
        .i_push        (w_ras_push),
        .i_pop         (w_ras_pop),
        .i_push_data   (w_ras_push_data),
        .i_restore     (w_recover),
        .i_restore_ptr (i_verify_ras_ptr),
        .o_top_c       (w_ras_top),
        .o_ptr         (w_ras_ptr),
        .o_count       (w_ras_count)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pred_valid   <= 1'b0;
            r_pred_br_op   <= 1'b0;
            r_pred_taken   <= 1'b0;
            r_pred_target  <= '0;
            r_pred_ras_ptr <= '0;
        end else if (i_fetch_valid) begin
            r_pred_valid   <= w_hit & w_idle;
            r_pred_br_op   <= w_hit;
            r_pred_taken   <= w_pred_taken;
            r_pred_target  <= w_pred_target;
            r_pred_ras_ptr <= w_ras_ptr;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Flush overrides every other transition.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:       if (w_mispred) w_state_next = ST_CORRECTION;
            ST_CORRECTION: if (i_correction_finish) w_state_next = ST_IDLE;
            default:       w_state_next = ST_IDLE;
        endcase
        if (i_pipeline_flush) begin
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_correct_target <= '0;
        end else if (w_recover) begin
            r_correct_target <= i_verify_target;
        end
    end

    assign o_pred_valid     = r_pred_valid;
    assign o_pred_br_op     = r_pred_br_op;
    assign o_pred_taken     = r_pred_taken;
    assign o_pred_target    = r_pred_target;
    assign o_pred_ras_ptr   = r_pred_ras_ptr;
    assign o_br_flush       = w_recover;
    assign o_is_correction  = (r_state == ST_CORRECTION);
    assign o_correct_target = r_correct_target;

endmodule
